// File: rtl/uart_tx_arbiter.sv
// Two-requester byte arbiter in front of a single UART sender: per-requester FIFOs,
// round-robin grant with an optional frame lock, start/done handshake with a timeout.
`timescale 1ns/1ps

module uart_tx_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 20000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] req0_data_i,
  input  logic       req0_valid_i,
  output logic       req0_ready_o,
  input  logic       req0_lock_i,
  input  logic [7:0] req1_data_i,
  input  logic       req1_valid_i,
  output logic       req1_ready_o,
  input  logic       req1_lock_i,
  output logic [7:0] send_data_o,
  output logic       send_start_o,
  input  logic       send_done_i,
  output logic       busy_o,
  output logic       tx_err_o
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);
  localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] PTR_ZERO  = {(AW + 1){1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // Full when the index bits match but the wrap bits differ.
  function automatic logic ptr_full(input logic [AW:0] wr, input logic [AW:0] rd);
    return (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  endfunction

  function automatic logic ptr_empty(input logic [AW:0] wr, input logic [AW:0] rd);
    return wr == rd;
  endfunction

  logic [7:0]  mem0_q [FIFO_DEPTH];
  logic [7:0]  mem1_q [FIFO_DEPTH];
  logic [AW:0] wr0_ptr_q;
  logic [AW:0] rd0_ptr_q;
  logic [AW:0] wr1_ptr_q;
  logic [AW:0] rd1_ptr_q;

  state_e      state_q;
  logic [7:0]  send_data_q;
  logic        send_start_q;
  logic        busy_q;
  logic        tx_err_q;
  logic        last_grant_q;
  logic        lock_vld_q;
  logic        lock_owner_q;
  logic [15:0] cnt_q;

  logic        full0_s;
  logic        full1_s;
  logic        empty0_s;
  logic        empty1_s;
  logic        push0_s;
  logic        push1_s;
  logic        pop0_s;
  logic        pop1_s;
  logic [7:0]  head0_s;
  logic [7:0]  head1_s;
  logic        owner_lock_s;
  logic        lock_hold_s;
  logic        lock_drop_s;
  logic        grant_vld_s;
  logic        grant_id_s;
  logic [15:0] cnt_inc_s;

  // FIFO status, handshake and head-of-queue views
  always_comb begin
    full0_s  = ptr_full(wr0_ptr_q, rd0_ptr_q);
    full1_s  = ptr_full(wr1_ptr_q, rd1_ptr_q);
    empty0_s = ptr_empty(wr0_ptr_q, rd0_ptr_q);
    empty1_s = ptr_empty(wr1_ptr_q, rd1_ptr_q);
    push0_s  = req0_valid_i & ~full0_s;
    push1_s  = req1_valid_i & ~full1_s;
    head0_s  = mem0_q[rd0_ptr_q[AW-1:0]];
    head1_s  = mem1_q[rd1_ptr_q[AW-1:0]];
  end

  // Grant selection while idle: a live lock pins the grant (or stalls), else round-robin
  always_comb begin
    owner_lock_s = lock_owner_q ? req1_lock_i : req0_lock_i;
    lock_hold_s  = lock_vld_q & owner_lock_s;
    lock_drop_s  = lock_vld_q & ~owner_lock_s;
    grant_vld_s  = 1'b0;
    grant_id_s   = 1'b0;
    if (state_q == ST_IDLE) begin
      if (lock_hold_s) begin
        grant_vld_s = lock_owner_q ? ~empty1_s : ~empty0_s;
        grant_id_s  = lock_owner_q;
      end else if (~empty0_s & ~empty1_s) begin
        grant_vld_s = 1'b1;
        grant_id_s  = ~last_grant_q;
      end else if (~empty0_s) begin
        grant_vld_s = 1'b1;
        grant_id_s  = 1'b0;
      end else if (~empty1_s) begin
        grant_vld_s = 1'b1;
        grant_id_s  = 1'b1;
      end else begin
        grant_vld_s = 1'b0;
        grant_id_s  = 1'b0;
      end
    end else begin
      grant_vld_s = 1'b0;
      grant_id_s  = 1'b0;
    end
    pop0_s    = grant_vld_s & ~grant_id_s;
    pop1_s    = grant_vld_s & grant_id_s;
    cnt_inc_s = cnt_q + 16'd1;
  end

  // FIFO storage; written only on an accepted push, so stored bytes never change
  always_ff @(posedge clk_i) begin
    if (push0_s) begin
      mem0_q[wr0_ptr_q[AW-1:0]] <= req0_data_i;
    end
    if (push1_s) begin
      mem1_q[wr1_ptr_q[AW-1:0]] <= req1_data_i;
    end
  end

  // FIFO pointers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr0_ptr_q <= PTR_ZERO;
      rd0_ptr_q <= PTR_ZERO;
      wr1_ptr_q <= PTR_ZERO;
      rd1_ptr_q <= PTR_ZERO;
    end else begin
      if (push0_s) begin
        wr0_ptr_q <= wr0_ptr_q + PTR_ONE;
      end
      if (pop0_s) begin
        rd0_ptr_q <= rd0_ptr_q + PTR_ONE;
      end
      if (push1_s) begin
        wr1_ptr_q <= wr1_ptr_q + PTR_ONE;
      end
      if (pop1_s) begin
        rd1_ptr_q <= rd1_ptr_q + PTR_ONE;
      end
    end
  end

  // Sender control FSM with registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      send_data_q  <= 8'h00;
      send_start_q <= 1'b0;
      busy_q       <= 1'b0;
      tx_err_q     <= 1'b0;
      last_grant_q <= 1'b1;
      lock_vld_q   <= 1'b0;
      lock_owner_q <= 1'b0;
      cnt_q        <= 16'd0;
    end else begin
      send_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_vld_s) begin
            send_data_q  <= grant_id_s ? head1_s : head0_s;
            last_grant_q <= grant_id_s;
            lock_owner_q <= grant_id_s;
            lock_vld_q   <= grant_id_s ? req1_lock_i : req0_lock_i;
            busy_q       <= 1'b1;
            state_q      <= ST_START;
          end else if (lock_drop_s) begin
            lock_vld_q <= 1'b0;
          end
        end
        ST_START: begin
          send_start_q <= 1'b1;
          cnt_q        <= 16'd0;
          state_q      <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done pulse wins over a timeout landing on the same edge.
          if (send_done_i) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (cnt_inc_s == TIMEOUT_C) begin
            cnt_q    <= cnt_inc_s;
            tx_err_q <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end else begin
            cnt_q <= cnt_inc_s;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req0_ready_o = ~full0_s;
  assign req1_ready_o = ~full1_s;
  assign send_data_o  = send_data_q;
  assign send_start_o = send_start_q;
  assign busy_o       = busy_q;
  assign tx_err_o     = tx_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a transaction-level reference model predicts every grant,
// and a monitor checks each SEND_START against the predicted byte and cycle.
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

  localparam int DEPTH = 4;
  localparam int TMO   = 40;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d0, d1;
  logic       v0, v1, l0, l1, done;
  logic       r0, r1, ss, busy, err;
  logic [7:0] sd;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req0_data_i(d0), .req0_valid_i(v0), .req0_ready_o(r0), .req0_lock_i(l0),
    .req1_data_i(d1), .req1_valid_i(v1), .req1_ready_o(r1), .req1_lock_i(l1),
    .send_data_o(sd), .send_start_o(ss), .send_done_i(done),
    .busy_o(busy), .tx_err_o(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: byte queues per requester plus the arbiter's busy window in edges.
  int         n = 0;
  logic [7:0] mq0[$], mq1[$];
  bit         m_busy, m_err, m_last, m_lock_v, m_own;
  int         m_gedge, m_free;
  logic [7:0] exp_d[$];
  int         exp_c[$];
  bit         acc0, acc1;
  int         g;
  logic [7:0] mb;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq0.delete(); mq1.delete(); exp_d.delete(); exp_c.delete();
        m_busy = 0; m_err = 0; m_last = 1; m_lock_v = 0; m_own = 0; m_free = 0; m_gedge = 0;
      end else begin
        n++;
        acc0 = v0 && (mq0.size() < DEPTH);
        acc1 = v1 && (mq1.size() < DEPTH);
        if (m_busy) begin
          if (done && n >= m_gedge + 2) begin
            m_busy = 0; m_free = n + 1;
          end else if (n == m_gedge + 1 + TMO) begin
            m_busy = 0; m_err = 1; m_free = n + 1;
          end
        end else if (n >= m_free) begin
          if (m_lock_v && !(m_own ? l1 : l0)) m_lock_v = 0;
          g = -1;
          if (m_lock_v) begin
            if (!m_own && mq0.size() > 0) g = 0;
            else if (m_own && mq1.size() > 0) g = 1;
          end else if (mq0.size() > 0 && mq1.size() > 0) g = m_last ? 0 : 1;
          else if (mq0.size() > 0) g = 0;
          else if (mq1.size() > 0) g = 1;
          if (g >= 0) begin
            mb = (g == 0) ? mq0.pop_front() : mq1.pop_front();
            exp_d.push_back(mb);
            exp_c.push_back(n + 1);
            m_last = (g == 1); m_own = (g == 1);
            m_lock_v = (g == 0) ? l0 : l1;
            m_busy = 1; m_gedge = n;
          end
        end
        if (acc0) mq0.push_back(d0);
        if (acc1) mq1.push_back(d1);
      end
    end
  end

  // Monitor: per-cycle status checks and scoreboard pop on every start pulse.
  logic [7:0] sent_q[$];
  int         start_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("busy", busy, m_busy);
        chk("tx_err", err, m_err);
        chk("ready0", r0, mq0.size() < DEPTH);
        chk("ready1", r1, mq1.size() < DEPTH);
        if (ss) begin
          start_cnt++;
          sent_q.push_back(sd);
          if (exp_d.size() == 0) chk("unexpected_start", ss, 1'b0);
          else begin
            chk("start_cycle", n, exp_c.pop_front());
            chk("send_data", sd, exp_d.pop_front());
          end
        end else if (exp_c.size() > 0 && exp_c[0] <= n) begin
          chk("missing_start", ss, 1'b1);
          void'(exp_c.pop_front());
          void'(exp_d.pop_front());
        end
      end
    end
  end

  // Sender responder: done after resp_delay cycles (0 = never), manual pulses, random noise.
  int resp_delay = 0;
  bit resp_rand  = 0;
  int man_req    = 0;
  int man_seen   = 0;
  int resp_cnt   = 0;

  initial begin
    done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        resp_cnt = 0; done = 1'b0;
      end else begin
        done = 1'b0;
        if (resp_cnt > 0) begin
          resp_cnt--;
          if (resp_cnt == 0) done = 1'b1;
        end
        if (man_req != man_seen) begin
          man_seen = man_req; done = 1'b1;
        end
        if (resp_rand && $urandom_range(0, 19) == 0) done = 1'b1;
        if (ss) resp_cnt = resp_rand ? int'($urandom_range(1, 8)) : resp_delay;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    v0 = 0; v1 = 0; l0 = 0; l1 = 0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_send_start", ss, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready0", r0, 1'b1);
    chk("rst_ready1", r1, 1'b1);
    chk("rst_send_data", sd, 8'h00);
    chk("rst_tx_err", err, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic push(input int r, input logic [7:0] d, output int hs);
    logic rdy;
    hs = -1;
    rdy = 1'b0;
    if (r == 0) begin v0 = 1; d0 = d; end else begin v1 = 1; d1 = d; end
    for (int i = 0; i < 200; i++) begin
      rdy = (r == 0) ? r0 : r1;
      tick();
      if (rdy) begin hs = n; break; end
    end
    if (r == 0) v0 = 0; else v1 = 0;
    if (hs < 0) chk("push_accept", rdy, 1'b1);
  endtask

  task automatic check_order(input string nm, input logic [7:0] expq[$]);
    for (int i = 0; i < 600 && sent_q.size() < expq.size(); i++) tick();
    chk({nm, "_count"}, sent_q.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      if (i < sent_q.size()) chk(nm, sent_q[i], expq[i]);
  endtask

  int         hs, tmp, sc;
  bit         found;
  logic [7:0] eq[$];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; v0 = 0; v1 = 0; l0 = 0; l1 = 0; d0 = 8'h00; d1 = 8'h00;

    // One byte: latency and single-cycle start pulse
    do_reset();
    resp_delay = 4; sent_q.delete();
    push(0, 8'h41, hs);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (ss) begin
        found = 1;
        chk("one_latency", n, hs + 2);
        chk("one_data", sd, 8'h41);
      end
    end
    chk("one_start_seen", found, 1'b1);
    @(negedge clk);
    chk("one_pulse_width", ss, 1'b0);
    chk("one_busy_hold", busy, 1'b1);
    tick();
    repeat (10) tick();
    chk("one_idle", busy, 1'b0);

    // Round-robin between two preloaded requesters
    do_reset();
    resp_delay = 5; sent_q.delete();
    v0 = 1; d0 = 8'h10; v1 = 1; d1 = 8'h20; tick();
    d0 = 8'h11; d1 = 8'h21; tick();
    v0 = 0; v1 = 0;
    eq = '{8'h10, 8'h20, 8'h11, 8'h21};
    check_order("rr_order", eq);

    // Lock keeps requester 1's frame together
    do_reset();
    resp_delay = 5; sent_q.delete();
    l1 = 1;
    push(1, 8'hA0, hs);
    push(0, 8'h01, hs);
    repeat (10) tick();
    push(1, 8'hA1, hs);
    repeat (10) tick();
    push(1, 8'hA2, hs);
    repeat (20) tick();
    chk("lock_stall_count", sent_q.size(), 3);
    l1 = 0;
    eq = '{8'hA0, 8'hA1, 8'hA2, 8'h01};
    check_order("lock_order", eq);

    // Full FIFO with the sender held busy
    do_reset();
    resp_delay = 0; sent_q.delete();
    for (int i = 0; i < 5; i++) push(0, 8'h30 + 8'(i), hs);
    v0 = 1; d0 = 8'h35;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("full_ready_low", r0, 1'b0);
    end
    resp_delay = 3;
    man_req++;
    push(0, 8'h35, hs);
    eq = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    check_order("full_order", eq);

    // Timeout: no done at all, then a later byte still goes out
    do_reset();
    resp_delay = 0; sent_q.delete();
    push(0, 8'h55, hs);
    found = 0;
    for (int i = 0; i < TMO + 20 && !found; i++) begin
      @(negedge clk);
      if (err) begin found = 1; chk("timeout_edge", n, hs + 2 + TMO); end
    end
    chk("timeout_seen", found, 1'b1);
    tick();
    resp_delay = 3; sent_q.delete();
    push(0, 8'h56, hs);
    eq = '{8'h56};
    check_order("after_timeout", eq);
    repeat (8) tick();
    chk("tx_err_sticky", err, 1'b1);

    // Reset in WAIT_DONE with bytes queued
    do_reset();
    resp_delay = 0;
    for (int i = 0; i < 4; i++) push(0, 8'h61 + 8'(i), hs);
    repeat (5) tick();
    chk("midop_busy_before", busy, 1'b1);
    do_reset();
    resp_delay = 3;
    sc = start_cnt;
    repeat (40) tick();
    tmp = start_cnt - sc;
    chk("no_stale_start", tmp, 0);

    // Randomised traffic with lock toggling and spurious done pulses
    do_reset();
    resp_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      v0 = ($urandom_range(0, 2) == 0); d0 = 8'($urandom_range(0, 255));
      v1 = ($urandom_range(0, 2) == 0); d1 = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) l0 = ~l0;
      if ($urandom_range(0, 15) == 0) l1 = ~l1;
      tick();
    end
    v0 = 0; v1 = 0; l0 = 0; l1 = 0;
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      tick();
      found = (exp_d.size() == 0 && mq0.size() == 0 && mq1.size() == 0 && !m_busy);
    end
    chk("random_drain", found, 1'b1);
    resp_rand = 0;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART sender between two byte producers: requester 0 is the CPU output port and requester 1 is the loopback/debug path. Each requester has a small FIFO behind a valid/ready handshake. The block picks bytes round-robin, with an optional lock that keeps a multi-byte frame unbroken. It drives the sender's start/done handshake and watches it with a timeout. It sits between the producers and the sender, in the same clock domain.

Parameters:
FIFO_DEPTH, 4, entries per requester FIFO; power of two, at least 2.
TIMEOUT, 20000, cycles allowed in WAIT_DONE for SEND_DONE before the byte is abandoned; must be less than 2^16.

Ports:
CLK  input  1  system clock; all logic on the rising edge.
RST_N  input  1  asynchronous, active-low reset.
REQ0_DATA  input  8  byte from requester 0.
REQ0_VALID  input  1  requester 0 offers REQ0_DATA.
REQ0_READY  output  1  FIFO 0 not full.
REQ0_LOCK  input  1  requester 0 asks to keep the grant between its bytes.
REQ1_DATA  input  8  byte from requester 1.
REQ1_VALID  input  1  requester 1 offers REQ1_DATA.
REQ1_READY  output  1  FIFO 1 not full.
REQ1_LOCK  input  1  requester 1 asks to keep the grant between its bytes.
SEND_DATA  output  8  byte to the sender; registered.
SEND_START  output  1  one-cycle pulse that starts the sender.
SEND_DONE  input  1  one-cycle pulse from the sender when its byte has been transmitted.
BUSY  output  1  high whenever state is not IDLE.
TX_ERR  output  1  sticky flag: a SEND_DONE timeout has occurred.

Behaviour:
- Reset (RST_N low, asynchronous):
  - state = IDLE; FIFOs empty; last_grant = 1 (so requester 0 wins first); lock owner cleared; timeout counter = 0.
  - SEND_DATA = 0, SEND_START = 0, BUSY = 0, TX_ERR = 0.
  - REQn_READY = 1, since it is the combinational value of "not full".
  - Reset during transmission aborts immediately. The sender itself is not reset by this block.
- FIFO push: when REQn_VALID & REQn_READY at a rising edge.
  - READY depends only on full. A full FIFO refuses a push even if a pop happens in the same cycle.
  - Data that the FIFO has accepted must not be altered.
  - Pointers are log2(FIFO_DEPTH) bits wide with an extra wrap bit to tell full from empty.
- State machine:
  - IDLE:
    - If a lock owner exists and REQ_LOCK of that owner is low, clear the lock; arbitration resumes in the same cycle.
    - If a lock owner exists and its FIFO is non-empty, grant the owner.
    - If a lock owner exists, its FIFO is empty and its LOCK is high, stall. The other requester is not granted.
    - With no lock: if both FIFOs are non-empty, grant the requester other than last_grant; otherwise grant the single non-empty FIFO.
    - On grant: pop the FIFO head into SEND_DATA, update last_grant, set lock owner = grantee if its REQ_LOCK is high, go to START.
  - START: SEND_START = 1 for this cycle only; clear the timeout counter; go to WAIT_DONE.
  - WAIT_DONE:
    - When SEND_DONE is seen, go to IDLE.
    - Otherwise increment the counter. When it reaches TIMEOUT, set TX_ERR, go to IDLE, and drop the byte without retry.
- SEND_DONE during IDLE or START is ignored.
- SEND_DATA holds its value from grant until the next grant.
- Latency: a byte accepted at edge t into an idle, empty arbiter is granted at edge t+1. SEND_START is high in the cycle after edge t+2.
- Back-to-back: a SEND_DONE at edge d gives IDLE in the following cycle. The next SEND_START is high in the cycle after edge d+2.
- TX_ERR is cleared only by reset.

Test Plan:
- One byte: reset, push 0x41 on req0 → SEND_DATA = 0x41, SEND_START high for exactly one cycle, 2 cycles after the handshake edge; BUSY stays 1 until SEND_DONE.
- Round-robin: preload req0 with 0x10, 0x11 and req1 with 0x20, 0x21; answer each start with SEND_DONE after 5 cycles → send order 0x10, 0x20, 0x11, 0x21.
- Lock: req1 holds LOCK high and pushes 0xA0, 0xA1, 0xA2 while req0 has 0x01 pending; req1 pauses 10 cycles between bytes → order 0xA0, 0xA1, 0xA2; 0x01 goes out only after REQ1_LOCK drops.
- Full FIFO: hold the sender busy (no SEND_DONE), push 6 bytes on req0 → the first byte is granted and the next 4 accepted; REQ0_READY goes low; the 6th is held off. After SEND_DONE, READY rises and all bytes leave in push order.
- Timeout: push 0x55 and never pulse SEND_DONE → after TIMEOUT cycles in WAIT_DONE, TX_ERR = 1 and state returns to IDLE. A following byte 0x56 is still sent, and TX_ERR stays 1.
- Reset mid-operation: assert RST_N low in WAIT_DONE with 3 bytes queued → SEND_START = 0, BUSY = 0, both READY = 1 immediately. After release, no stale byte is sent.
